image_fetch: RTL and testbench

- Upstream feeder for the ANN core: on a start request, fetches one 8x8 grayscale image (64 x 8-bit pixels) from external pixel memory and assembles it into a parallel pixel buffer.
- Presents the buffer to the network with a valid/consume handshake, one image per start.
- Sits between the start_detecting/image_address control inputs and the NN layer engine.

---
 rtl/ann_pkg.sv | 19 +
 rtl/image_fetch_if.sv | 26 ++
 rtl/pixel_buffer.sv | 25 ++
 rtl/image_fetch.sv | 86 ++++++++
 tb/tb_image_fetch.sv | 310 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ann_pkg.sv
// Shared types and sizing for the ANN input path: pixel/image types and the
// image fetch state encoding.
package ann_pkg;
  localparam int NUM_PIXELS = 64;
  localparam int PIXEL_W    = 8;
  localparam int PIX_IDX_W  = $clog2(NUM_PIXELS);
  localparam int IMG_IDX_W  = 10;
  localparam int ADDR_W     = IMG_IDX_W + PIX_IDX_W;

  typedef logic [PIXEL_W-1:0]         pixel_t;
  typedef pixel_t [NUM_PIXELS-1:0]    image_t;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DONE
  } fetch_state_t;
endpackage

// File: rtl/image_fetch_if.sv
// Control, pixel-memory and image-output signals of the image fetcher.
// The master modport is the fetcher side; slave is its environment.
interface image_fetch_if;
  import ann_pkg::*;

  logic                 start_detecting;
  logic [IMG_IDX_W-1:0] image_address;
  logic                 mem_rd;
  logic [ADDR_W-1:0]    mem_addr;
  pixel_t               mem_rdata;
  logic                 mem_rvalid;
  logic                 get_image;
  image_t               image_data;
  logic                 image_valid;
  logic                 busy;

  modport master (
    input  start_detecting, image_address, mem_rdata, mem_rvalid, get_image,
    output mem_rd, mem_addr, image_data, image_valid, busy
  );

  modport slave (
    output start_detecting, image_address, mem_rdata, mem_rvalid, get_image,
    input  mem_rd, mem_addr, image_data, image_valid, busy
  );
endinterface

// File: rtl/pixel_buffer.sv
// Indexed pixel register array with a single write port and a flat image view.
module pixel_buffer
  import ann_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 we,
  input  logic [PIX_IDX_W-1:0] idx,
  input  pixel_t               wdata,
  output image_t               image_data
);

  image_t pixels;

  always_ff @(posedge clk) begin
    if (reset) begin
      pixels <= '0;
    end else if (we) begin
      pixels[idx] <= wdata;
    end
  end

  assign image_data = pixels;

endmodule

// File: rtl/image_fetch.sv
// Fetches one 8x8 image from pixel memory, one outstanding read at a time,
// and holds it for the NN engine until consumed.
//
//   state | meaning
//   IDLE  | waiting for start_detecting; buffer keeps the last image
//   REQ   | one-cycle mem_rd for pixel cnt of image idx
//   WAIT  | waiting for mem_rvalid; address held
//   DONE  | image complete, image_valid high until get_image
module image_fetch
  import ann_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  image_fetch_if.master bus
);

  fetch_state_t         state, state_next;
  logic [PIX_IDX_W-1:0] cnt, cnt_next;
  logic [IMG_IDX_W-1:0] idx, idx_next;
  logic                 buf_we;
  logic                 last_pixel;
  image_t               buf_image;

  assign last_pixel = (cnt == PIX_IDX_W'(NUM_PIXELS - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      idx   <= idx_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    idx_next   = idx;
    buf_we     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start_detecting) begin
          idx_next   = bus.image_address;
          cnt_next   = '0;
          state_next = REQ;
        end
      end
      REQ: state_next = WAIT;
      WAIT: begin
        if (bus.mem_rvalid) begin
          buf_we = 1'b1;
          // terminal count ends the fetch, so the counter never wraps
          if (last_pixel) begin
            state_next = DONE;
          end else begin
            cnt_next   = cnt + PIX_IDX_W'(1);
            state_next = REQ;
          end
        end
      end
      DONE: begin
        if (bus.get_image) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  pixel_buffer u_pixel_buffer (
    .clk        (clk),
    .reset      (reset),
    .we         (buf_we),
    .idx        (cnt),
    .wdata      (bus.mem_rdata),
    .image_data (buf_image)
  );

  assign bus.mem_rd      = (state == REQ);
  assign bus.mem_addr    = {idx, cnt};
  assign bus.busy        = (state == REQ) || (state == WAIT);
  assign bus.image_valid = (state == DONE);
  assign bus.image_data  = buf_image;

endmodule

// File: tb/tb_image_fetch.sv
// Scoreboard bench for image_fetch: a latency-configurable pixel memory model
// pushes expected pixels, a read monitor pops expected addresses.
module tb_image_fetch;
  import ann_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  image_fetch_if bus ();
  image_fetch dut (.clk(clk), .reset(reset), .bus(bus));

  int vectors = 0;
  int miscompares = 0;

  logic   resp_valid = 1'b0;
  logic   spur_valid = 1'b0;
  pixel_t resp_data  = '0;
  pixel_t spur_data  = '0;
  assign bus.mem_rvalid = resp_valid | spur_valid;
  assign bus.mem_rdata  = spur_valid ? spur_data : resp_data;

  int  fixed_lat  = 1;
  int  resp_count = 0;
  int  rd_count   = 0;
  bit  outstanding = 1'b0;
  logic [ADDR_W-1:0] exp_addr_q[$];
  pixel_t            exp_pix_q[$];
  image_t            exp_img;
  logic [ADDR_W-1:0] mon_ea, mon_first, mon_last;
  logic [ADDR_W-1:0] resp_addr;
  int                resp_lat;

  // pixel memory: data = addr[7:0] ^ A5, latency fixed or random 1..5
  initial begin
    forever begin
      @(negedge clk);
      if (bus.mem_rd === 1'b1 && reset === 1'b0) begin
        resp_addr = bus.mem_addr;
        resp_lat  = (fixed_lat != 0) ? fixed_lat : int'($urandom_range(1, 5));
        repeat (resp_lat) @(posedge clk);
        #1;
        resp_data  = resp_addr[7:0] ^ 8'hA5;
        resp_valid = 1'b1;
        exp_pix_q.push_back(resp_data);
        resp_count++;
        @(posedge clk);
        #1 resp_valid = 1'b0;
      end
    end
  end

  // read monitor: address order and single outstanding read
  initial begin
    forever begin
      @(negedge clk);
      if (resp_valid) outstanding = 1'b0;
      if (bus.mem_rd === 1'b1) begin
        rd_count++;
        if (rd_count == 1) mon_first = bus.mem_addr;
        mon_last = bus.mem_addr;
        vectors++;
        if (outstanding !== 1'b0) begin
          miscompares++;
          $display("FAIL overlap_rd: outstanding=%0b at mem_rd, required 0", outstanding);
        end
        outstanding = 1'b1;
        vectors++;
        if (exp_addr_q.size() == 0) begin
          miscompares++;
          $display("FAIL mem_addr: got %h, required no read", bus.mem_addr);
        end else begin
          mon_ea = exp_addr_q.pop_front();
          if (bus.mem_addr !== mon_ea) begin
            miscompares++;
            $display("FAIL mem_addr: got %h, required %h", bus.mem_addr, mon_ea);
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    miscompares++;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic run_fetch(input logic [IMG_IDX_W-1:0] idx, input bit disturb,
                           input bit spur_req, output int cycles);
    for (int k = 0; k < NUM_PIXELS; k++) exp_addr_q.push_back({idx, PIX_IDX_W'(k)});
    rd_count = 0;
    bus.image_address   = idx;
    bus.start_detecting = 1'b1;
    @(posedge clk);
    #1;
    bus.start_detecting = 1'b0;
    cycles = 1;
    if (spur_req) begin
      spur_data  = 8'hEE;
      spur_valid = 1'b1;
    end
    while (bus.image_valid !== 1'b1 && cycles < 1000) begin
      if (disturb && bus.busy === 1'b1 && (cycles % 9) == 4) begin
        bus.start_detecting = 1'b1;
        bus.image_address   = IMG_IDX_W'($urandom);
        bus.get_image       = 1'b1;
      end
      @(posedge clk);
      #1;
      cycles++;
      spur_valid          = 1'b0;
      bus.start_detecting = 1'b0;
      bus.get_image       = 1'b0;
    end
    vectors++;
    if (bus.image_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL fetch_timeout: image_valid=%b after %0d cycles, required 1", bus.image_valid, cycles);
    end
    vectors++;
    if (rd_count != NUM_PIXELS) begin
      miscompares++;
      $display("FAIL rd_count: got %0d reads, required %0d", rd_count, NUM_PIXELS);
    end
    vectors++;
    if (exp_pix_q.size() != NUM_PIXELS) begin
      miscompares++;
      $display("FAIL resp_count: got %0d responses, required %0d", exp_pix_q.size(), NUM_PIXELS);
      exp_pix_q.delete();
    end else begin
      for (int k = 0; k < NUM_PIXELS; k++) exp_img[k] = exp_pix_q.pop_front();
      for (int k = 0; k < NUM_PIXELS; k++) begin
        vectors++;
        if (bus.image_data[k] !== exp_img[k]) begin
          miscompares++;
          $display("FAIL pixel[%0d]: got %h, required %h", k, bus.image_data[k], exp_img[k]);
        end
      end
    end
  endtask

  task automatic consume();
    bus.get_image = 1'b1;
    @(posedge clk);
    #1 bus.get_image = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.start_detecting = 1'b0;
    bus.image_address   = '0;
    bus.get_image       = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (bus.mem_rd !== 1'b0 || bus.busy !== 1'b0 || bus.image_valid !== 1'b0 ||
        bus.mem_addr !== '0 || bus.image_data !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: rd=%b busy=%b valid=%b addr=%h, required all 0",
               bus.mem_rd, bus.busy, bus.image_valid, bus.mem_addr);
    end
    reset = 1'b0;
    rd_count = 0;
    repeat (20) @(posedge clk);
    #1;
    vectors++;
    if (rd_count != 0) begin
      miscompares++;
      $display("FAIL idle_no_rd: got %0d reads, required 0", rd_count);
    end
  endtask

  task automatic test_full_fetch();
    int cyc;
    fixed_lat = 1;
    run_fetch(10'd3, 1'b0, 1'b0, cyc);
    vectors++;
    if (cyc != 129) begin
      miscompares++;
      $display("FAIL fetch_latency: got %0d cycles, required 129", cyc);
    end
    vectors++;
    if (mon_first !== 16'h00C0 || mon_last !== 16'h00FF) begin
      miscompares++;
      $display("FAIL addr_range: got %h..%h, required 00c0..00ff", mon_first, mon_last);
    end
    vectors++;
    if (bus.image_data[0] !== 8'h65 || bus.image_data[63] !== 8'h5A) begin
      miscompares++;
      $display("FAIL pixel_ends: got %h/%h, required 65/5a", bus.image_data[0], bus.image_data[63]);
    end
  endtask

  task automatic test_handshake();
    int rd_before;
    rd_before = rd_count;
    for (int c = 0; c < 10; c++) begin
      bus.start_detecting = (c == 3);
      @(posedge clk);
      #1;
      bus.start_detecting = 1'b0;
      vectors++;
      if (bus.image_valid !== 1'b1 || bus.image_data !== exp_img) begin
        miscompares++;
        $display("FAIL done_hold[%0d]: valid=%b, required 1 with stable image", c, bus.image_valid);
      end
    end
    vectors++;
    if (rd_count != rd_before) begin
      miscompares++;
      $display("FAIL start_in_done: got %0d reads, required %0d", rd_count, rd_before);
    end
    consume();
    vectors++;
    if (bus.image_valid !== 1'b0 || bus.busy !== 1'b0 || dut.state !== IDLE ||
        bus.image_data !== exp_img) begin
      miscompares++;
      $display("FAIL consume: valid=%b busy=%b state=%0d, required 0 0 IDLE with image kept",
               bus.image_valid, bus.busy, dut.state);
    end
  endtask

  task automatic test_spurious_idle();
    spur_data  = 8'hEE;
    spur_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1 spur_valid = 1'b0;
    vectors++;
    if (bus.image_data !== exp_img || bus.busy !== 1'b0 || bus.image_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL spurious_idle: busy=%b valid=%b pixel0=%h, required 0 0 %h",
               bus.busy, bus.image_valid, bus.image_data[0], exp_img[0]);
    end
  endtask

  task automatic test_variable_latency();
    int cyc;
    fixed_lat = 0;
    run_fetch(10'h155, 1'b1, 1'b1, cyc);
    consume();
  endtask

  task automatic test_reset_mid_fetch();
    int base, n, cyc;
    fixed_lat = 2;
    for (int k = 0; k < NUM_PIXELS; k++) exp_addr_q.push_back({10'd5, PIX_IDX_W'(k)});
    base = resp_count;
    bus.image_address   = 10'd5;
    bus.start_detecting = 1'b1;
    @(posedge clk);
    #1 bus.start_detecting = 1'b0;
    n = 0;
    while (resp_count - base < 21 && n < 1000) begin
      @(posedge clk);
      #2;
      n++;
    end
    vectors++;
    if (resp_count - base < 21) begin
      miscompares++;
      $display("FAIL mid_wait: got %0d pixels, required 21", resp_count - base);
    end
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    vectors++;
    if (bus.mem_rd !== 1'b0 || bus.busy !== 1'b0 || bus.image_valid !== 1'b0 ||
        bus.mem_addr !== '0 || bus.image_data !== '0) begin
      miscompares++;
      $display("FAIL reset_mid: rd=%b busy=%b valid=%b addr=%h, required all 0",
               bus.mem_rd, bus.busy, bus.image_valid, bus.mem_addr);
    end
    repeat (8) @(posedge clk);
    #1;
    vectors++;
    if (bus.image_data !== '0 || bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL late_rvalid: busy=%b pixel20=%h, required 0 00", bus.busy, bus.image_data[20]);
    end
    exp_addr_q.delete();
    exp_pix_q.delete();
    outstanding = 1'b0;
    run_fetch(10'd1023, 1'b0, 1'b0, cyc);
    vectors++;
    if (mon_first !== 16'hFFC0 || mon_last !== 16'hFFFF) begin
      miscompares++;
      $display("FAIL addr_range_top: got %h..%h, required ffc0..ffff", mon_first, mon_last);
    end
    vectors++;
    if (cyc != 64 * 3 + 1) begin
      miscompares++;
      $display("FAIL fetch_latency_l2: got %0d cycles, required %0d", cyc, 64 * 3 + 1);
    end
    consume();
  endtask

  initial begin
    test_reset();
    test_full_fetch();
    test_handshake();
    test_spurious_idle();
    test_variable_latency();
    test_reset_mid_fetch();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
